// File: rtl/d_ip_uart_tx_arb.sv
// Round-robin, packet-locked arbiter feeding the UART TX FIFO push port.
// A grant is held until the owner's last beat or until the stall timeout expires.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no owner; pick next requester after rr_ptr
// ST_XFER | grant_id owns the FIFO port until last beat or stall timeout
module d_ip_uart_tx_arb #(
  parameter int N_REQ   = 4,
  parameter int DATA_WD = 8,
  parameter int TMO_WD  = 8,
  localparam int GID_WD = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_WD-1:0] req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DATA_WD-1:0]       fifo_wdata,
  input  logic [TMO_WD-1:0]        tmo_cfg,
  output logic [GID_WD-1:0]        grant_id,
  output logic                     busy,
  output logic                     tmo_irq
);

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t              state;
  logic [GID_WD-1:0]   rr_ptr;
  logic [TMO_WD-1:0]   stall_cnt;
  logic                win_found;
  logic [GID_WD-1:0]   win_id;
  logic                own_valid;
  logic                own_last;
  logic                beat;
  logic                tmo_hit;

  // Search starts just past the previous owner so it gets lowest priority.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = GID_WD'(idx);
      end
    end
  end

  assign own_valid  = req_valid[grant_id];
  assign own_last   = req_last[grant_id];
  assign beat       = (state == ST_XFER) && own_valid && !fifo_full;
  assign fifo_wr_en = beat;
  assign fifo_wdata = req_data[int'(grant_id)*DATA_WD +: DATA_WD];
  // Compare with >= so a tmo_cfg lowered below the running count fires at once.
  assign tmo_hit    = (tmo_cfg != '0) && (stall_cnt >= (tmo_cfg - TMO_WD'(1)));

  always_comb begin
    req_ready = '0;
    if ((state == ST_XFER) && !fifo_full) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      rr_ptr    <= GID_WD'(N_REQ - 1);
      grant_id  <= '0;
      busy      <= 1'b0;
      tmo_irq   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      tmo_irq <= 1'b0;
      case (state)
        ST_IDLE: begin
          stall_cnt <= '0;
          if (win_found) begin
            grant_id <= win_id;
            busy     <= 1'b1;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat) begin
            stall_cnt <= '0;
            if (own_last) begin
              rr_ptr <= grant_id;
              busy   <= 1'b0;
              state  <= ST_IDLE;
            end
          end else if (fifo_full) begin
            stall_cnt <= '0;
          end else if (tmo_hit) begin
            rr_ptr    <= grant_id;
            busy      <= 1'b0;
            tmo_irq   <= 1'b1;
            stall_cnt <= '0;
            state     <= ST_IDLE;
          end else if (stall_cnt != {TMO_WD{1'b1}}) begin
            stall_cnt <= stall_cnt + TMO_WD'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_ip_uart_tx_arb.sv
// Bench for d_ip_uart_tx_arb: packet sources, a cycle model of the arbitration
// rules, per-cycle output comparison and directed literal checks per scenario.
module tb_d_ip_uart_tx_arb;
  localparam int N = 4;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        fifo_full, fifo_wr_en;
  logic [7:0]  fifo_wdata, tmo_cfg;
  logic [1:0]  grant_id;
  logic        busy, tmo_irq;

  d_ip_uart_tx_arb #(.N_REQ(4), .DATA_WD(8), .TMO_WD(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .tmo_cfg(tmo_cfg),
    .grant_id(grant_id), .busy(busy), .tmo_irq(tmo_irq)
  );

  always #5 PCLK = ~PCLK;

  int n_pass = 0, n_chk = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Packet sources: one byte queue per requester, {last, data}.
  logic [8:0] src_mem [4][32];
  int         src_hd [4];
  int         src_tl [4];
  logic [3:0] pop_flag;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_hd[i] < src_tl[i]) begin
        req_valid[i]         = 1'b1;
        req_data[i*8 +: 8]   = src_mem[i][src_hd[i]][7:0];
        req_last[i]          = src_mem[i][src_hd[i]][8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*8 +: 8]   = 8'h00;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic add(input int i, input logic last, input logic [7:0] d);
    if (src_tl[i] < 32) begin
      src_mem[i][src_tl[i]] = {last, d};
      src_tl[i]++;
    end
  endtask

  task automatic clr_src();
    for (int i = 0; i < N; i++) begin
      src_hd[i] = 0;
      src_tl[i] = 0;
    end
    drive();
  endtask

  always @(negedge PCLK) pop_flag = req_valid & req_ready & {4{~PRESET}};

  always @(posedge PCLK) begin
    #1;
    for (int i = 0; i < N; i++)
      if (pop_flag[i] === 1'b1 && src_hd[i] < src_tl[i]) src_hd[i]++;
    drive();
  end

  // Reference model: owner (-1 = none), round-robin pointer, stall cycle count.
  int   m_owner = -1;
  int   m_rr    = N - 1;
  int   m_cnt   = 0;
  logic m_irq   = 1'b0;

  always @(posedge PCLK) begin : model
    int w;
    w = -1;
    if (PRESET) begin
      m_owner <= -1;
      m_rr    <= N - 1;
      m_cnt   <= 0;
      m_irq   <= 1'b0;
    end else begin
      m_irq <= 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        if (w >= 0) begin
          m_owner <= w;
          m_cnt   <= 0;
        end
      end else if (req_valid[m_owner] && !fifo_full) begin
        m_cnt <= 0;
        if (req_last[m_owner]) begin
          m_rr    <= m_owner;
          m_owner <= -1;
        end
      end else if (fifo_full) begin
        m_cnt <= 0;
      end else if (tmo_cfg != 0 && m_cnt + 1 >= int'(tmo_cfg)) begin
        m_rr    <= m_owner;
        m_owner <= -1;
        m_irq   <= 1'b1;
        m_cnt   <= 0;
      end else begin
        m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  end

  // Observation logs used by the directed literal checks.
  int   obs_pd[$], obs_pc[$], obs_gg[$], obs_gc[$], obs_fall[$], obs_irq[$];
  logic prev_busy = 1'b0;

  task automatic clr_logs();
    obs_pd.delete(); obs_pc.delete(); obs_gg.delete();
    obs_gc.delete(); obs_fall.delete(); obs_irq.delete();
  endtask

  always @(negedge PCLK) begin : cmp
    logic [3:0] er;
    logic       ew;
    if (chk_en) begin
      er = 4'b0000;
      ew = 1'b0;
      if (m_owner >= 0 && !fifo_full) begin
        er[m_owner] = 1'b1;
        ew          = req_valid[m_owner];
      end
      chk("busy", busy, m_owner >= 0);
      chk("tmo_irq", tmo_irq, m_irq);
      chk("req_ready", req_ready, er);
      chk("fifo_wr_en", fifo_wr_en, ew);
      if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
      if (ew) chk("fifo_wdata", fifo_wdata, req_data[m_owner*8 +: 8]);
      if (fifo_wr_en === 1'b1) begin
        obs_pd.push_back(int'(fifo_wdata));
        obs_pc.push_back(cyc);
      end
      if (busy === 1'b1 && !prev_busy) begin
        obs_gg.push_back(int'(grant_id));
        obs_gc.push_back(cyc);
      end
      if (busy === 1'b0 && prev_busy) obs_fall.push_back(cyc);
      if (tmo_irq === 1'b1) obs_irq.push_back(cyc);
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #2;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    clr_src();
    step(1);
    PRESET = 1'b0;
  endtask

  task automatic wait_push(input int n, input int budget);
    int t = 0;
    while (obs_pd.size() < n && t < budget) begin
      @(negedge PCLK); #1;
      t++;
    end
    chk("wait_push", obs_pd.size() >= n, 1);
  endtask

  task automatic wait_grant(input int n, input int budget);
    int t = 0;
    while (obs_gg.size() < n && t < budget) begin
      @(negedge PCLK); #1;
      t++;
    end
    chk("wait_grant", obs_gg.size() >= n, 1);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  int t0, tf, tc, tr;

  initial begin
    PRESET    = 1'b1;
    fifo_full = 1'b0;
    tmo_cfg   = 8'd0;
    clr_src();
    step(3);
    PRESET = 1'b0;
    chk_en = 1'b1;
    @(negedge PCLK);
    chk("rst_busy", busy, 0);
    chk("rst_irq", tmo_irq, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr", fifo_wr_en, 0);
    step(1);

    // Single 3-byte packet from requester 2.
    clr_logs();
    add(2, 1'b0, 8'h41); add(2, 1'b0, 8'h42); add(2, 1'b1, 8'h43);
    drive();
    t0 = cyc;
    wait_push(3, 20);
    step(3);
    chk("t1_ngrant", obs_gg.size(), 1);
    chk("t1_gid", qat(obs_gg, 0), 2);
    chk("t1_gcyc", qat(obs_gc, 0), t0 + 1);
    for (int i = 0; i < 3; i++) begin
      chk("t1_data", qat(obs_pd, i), 32'h41 + i);
      chk("t1_pcyc", qat(obs_pc, i), t0 + 1 + i);
    end
    chk("t1_npush", obs_pd.size(), 3);
    chk("t1_fall", qat(obs_fall, 0), t0 + 4);

    // Round-robin over four continuous 1-byte streams.
    do_reset();
    clr_logs();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) add(i, 1'b1, 8'(i * 16 + k));
    drive();
    t0 = cyc;
    wait_push(12, 100);
    step(2);
    for (int n = 0; n < 12; n++) begin
      chk("t2_gid", qat(obs_gg, n), n % 4);
      chk("t2_gcyc", qat(obs_gc, n), t0 + 1 + 2 * n);
      chk("t2_data", qat(obs_pd, n), (n % 4) * 16 + n / 4);
      chk("t2_pcyc", qat(obs_pc, n), t0 + 1 + 2 * n);
    end

    // Packet lock: requester 1 waits for requester 0's last beat.
    do_reset();
    clr_logs();
    for (int k = 0; k < 4; k++) add(0, k == 3, 8'hA0 + 8'(k));
    add(1, 1'b0, 8'hB0); add(1, 1'b1, 8'hB1);
    drive();
    t0 = cyc;
    wait_push(6, 40);
    step(2);
    for (int k = 0; k < 4; k++) begin
      chk("t3_adata", qat(obs_pd, k), 32'hA0 + k);
      chk("t3_acyc", qat(obs_pc, k), t0 + 1 + k);
    end
    chk("t3_b0", qat(obs_pd, 4), 32'hB0);
    chk("t3_b0cyc", qat(obs_pc, 4), t0 + 6);
    chk("t3_b1", qat(obs_pd, 5), 32'hB1);
    chk("t3_g1", qat(obs_gg, 1), 1);

    // Backpressure for 20 cycles never counts toward the timeout.
    do_reset();
    clr_logs();
    tmo_cfg = 8'd5;
    for (int k = 0; k < 4; k++) add(1, k == 3, 8'hC0 + 8'(k));
    drive();
    t0 = cyc;
    wait_push(2, 20);
    step(1);
    fifo_full = 1'b1;
    step(20);
    fifo_full = 1'b0;
    tf = cyc;
    wait_push(4, 20);
    step(2);
    chk("t4_nirq", obs_irq.size(), 0);
    chk("t4_ngrant", obs_gg.size(), 1);
    chk("t4_p2cyc", qat(obs_pc, 2), tf);
    chk("t4_p2", qat(obs_pd, 2), 32'hC2);
    chk("t4_p3cyc", qat(obs_pc, 3), tf + 1);

    // Stall timeout on requester 3, then requester 0 gets the port.
    do_reset();
    clr_logs();
    tmo_cfg = 8'd5;
    add(3, 1'b0, 8'hD0);
    drive();
    t0 = cyc;
    wait_grant(1, 20);
    step(1);
    add(0, 1'b1, 8'hE0);
    drive();
    step(12);
    chk("t5_g0", qat(obs_gg, 0), 3);
    chk("t5_g0cyc", qat(obs_gc, 0), t0 + 1);
    chk("t5_nirq", obs_irq.size(), 1);
    chk("t5_irqcyc", qat(obs_irq, 0), t0 + 7);
    chk("t5_fall", qat(obs_fall, 0), t0 + 7);
    chk("t5_g1", qat(obs_gg, 1), 0);
    chk("t5_g1cyc", qat(obs_gc, 1), t0 + 8);
    chk("t5_e0", qat(obs_pd, 1), 32'hE0);

    // tmo_cfg=0 never times out; counter saturates, new tmo_cfg applies at once.
    do_reset();
    clr_logs();
    tmo_cfg = 8'd0;
    add(2, 1'b0, 8'hF0);
    drive();
    t0 = cyc;
    step(258);
    chk("t7_nirq0", obs_irq.size(), 0);
    chk("t7_nfall0", obs_fall.size(), 0);
    tmo_cfg = 8'd3;
    tc = cyc;
    step(3);
    chk("t7_irqcyc", qat(obs_irq, 0), tc + 1);
    chk("t7_fall", qat(obs_fall, 0), tc + 1);

    // Reset during the second beat of requester 1's packet.
    do_reset();
    clr_logs();
    tmo_cfg = 8'd0;
    add(0, 1'b1, 8'h50);
    for (int k = 0; k < 3; k++) add(1, k == 2, 8'h60 + 8'(k));
    drive();
    t0 = cyc;
    wait_push(2, 20);
    step(1);
    PRESET = 1'b1;
    step(1);
    PRESET = 1'b0;
    clr_src();
    clr_logs();
    @(negedge PCLK);
    chk("t6_busy", busy, 0);
    chk("t6_wr", fifo_wr_en, 0);
    chk("t6_ready", req_ready, 0);
    step(1);
    add(0, 1'b1, 8'h70);
    add(1, 1'b1, 8'h71);
    drive();
    tr = cyc;
    step(6);
    chk("t6_g0", qat(obs_gg, 0), 0);
    chk("t6_g0cyc", qat(obs_gc, 0), tr + 1);
    chk("t6_g1", qat(obs_gg, 1), 1);
    chk("t6_npush", obs_pd.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
